pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage RV32 pipeline (F/D/E/M/W).
- Drives the stall (enable) and clr inputs of every inter-stage pipeline register.
- Selects E-stage operand forwarding.
- Sequences two multi-cycle events with a small FSM: multi-cycle MUL/DIV occupancy of E, and data-memory wait states in M, with timeout.

Parameters:
MULDIV_LAT, 4, total cycles a MUL/DIV instruction occupies E (>=1; 1 = no stall)
MEM_TIMEOUT, 255, max consecutive dmem wait cycles before abort (>=1)
CNT_WIDTH, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
Rs1D, Rs2D  in  5  source regs of instr in D
Rs1E, Rs2E  in  5  source regs of instr in E
RdE, RdM, RdW  in  5  dest regs in E/M/W
RegWriteM, RegWriteW  in  1  M/W instr writes regfile
ResultSrcE  in  2  E result select; 2'b01 = load
PCSrcE  in  1  taken branch/jump resolved in E
MulDivE  in  1  E holds MUL/DIV instr
MemReqM  in  1  M holds load/store
MemReadyM  in  1  dmem completes access this cycle
StallF, StallD, StallE, StallM  out  1  hold stage register
FlushD, FlushE, FlushM, FlushW  out  1  clr stage register (insert bubble)
ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
MemTimeout  out  1  one-cycle pulse on dmem abort
StallCount  out  CNT_WIDTH  cycles with StallF=1

Behaviour:
- FSM states: RUN, MD_BUSY, MEM_WAIT.
- Reset (rst=1 at edge): state=RUN, md_cnt=0, wait_cnt=0, StallCount=0.
- While rst=1, all Stall*/Flush*/MemTimeout outputs = 0 and Forward* = 00, regardless of inputs.
- Reset mid-MD_BUSY/MEM_WAIT: abandon, RUN next cycle.
- Forwarding (combinational, per operand, Rs1E shown):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - else 00. M has priority over W.
- memStall, RUN: MemReqM && !MemReadyM.
  - Assert StallF/D/E/M and FlushW this cycle.
  - wait_cnt<=1; next MEM_WAIT.
  - Highest priority.
- mdStall, RUN, no memStall: MulDivE && MULDIV_LAT>1.
  - Assert StallF/D/E and FlushM this cycle.
  - md_cnt<=MULDIV_LAT-2; next MD_BUSY.
- MD_BUSY:
  - md_cnt!=0: StallF/D/E + FlushM, md_cnt--.
  - md_cnt==0: release cycle, no md stall, next RUN.
  - E therefore holds the instr exactly MULDIV_LAT cycles; stall cycles = MULDIV_LAT-1.
  - MemReqM/MemReadyM ignored in MD_BUSY (M holds bubbles).
- MEM_WAIT:
  - MemReadyM=1: no mem stall this cycle, next RUN.
  - else if wait_cnt==MEM_TIMEOUT: no stall, FlushW=0; FlushM=1 (drop nothing new, restart M); MemTimeout=1; next RUN.
  - else: StallF/D/E/M + FlushW, wait_cnt++.
- Load-use, evaluated only when no FSM stall this cycle:
  - lwStall = ResultSrcE==2'b01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - lwStall asserts StallF, StallD, FlushE.
- Branch:
  - FlushD = PCSrcE && !StallE.
  - FlushE = (PCSrcE || lwStall) && !StallE.
  - While E is held, the branch flush is deferred until E advances; PCSrcE stays asserted by the datapath.
- Simultaneous lwStall && PCSrcE: FlushD=1, FlushE=1, StallF=StallD=1; the next-PC mux takes the branch.
- StallCount: +1 each cycle StallF=1, saturates at all-ones (no wrap).

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Set RdM=0 -> ForwardAE=01. Set Rs1E=0 with RdW=0 -> 00.
- Load in E (ResultSrcE=01, RdE=7), Rs2D=7 -> exactly 1 cycle StallF=StallD=FlushE=1. With RdE=0 -> no stall.
- MulDivE=1, MULDIV_LAT=4 -> StallF/D/E + FlushM for 3 consecutive cycles, 4th cycle clear, StallCount=3. MULDIV_LAT=1 -> no stall.
- MemReqM=1, MemReadyM low 5 cycles then high -> StallF/D/E/M + FlushW for 5 cycles, released on ready cycle, state RUN.
- MemReadyM held 0, MEM_TIMEOUT=3 -> stalls 3 cycles, then MemTimeout pulse + FlushM, back to RUN.
- PCSrcE=1 during MEM_WAIT -> FlushD/FlushE stay 0 until ready cycle, then 1. Assert rst mid-MD_BUSY -> all outputs 0, RUN after edge, StallCount=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32 pipeline.
// A small FSM sequences multi-cycle MUL/DIV occupancy of E and dmem wait states in M.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT  = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic                 MulDivE,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic                 FlushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 MemTimeout,
  output logic [CNT_WIDTH-1:0] StallCount
);

  localparam int MDW     = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
  localparam int WW      = $clog2(MEM_TIMEOUT + 1);
  localparam int MD_INIT = (MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0;

  typedef enum logic [1:0] {RUN, MD_BUSY, MEM_WAIT} state_t;

  state_t         state, stateNext;
  logic [MDW-1:0] mdCnt, mdCntNext;
  logic [WW-1:0]  waitCnt, waitCntNext;
  logic           memStall, mdStall, memAbort, lwStall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      mdCnt   <= '0;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      mdCnt   <= mdCntNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    mdCntNext   = mdCnt;
    waitCntNext = waitCnt;
    memStall    = 1'b0;
    mdStall     = 1'b0;
    memAbort    = 1'b0;
    case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          memStall    = 1'b1;
          waitCntNext = WW'(1);
          stateNext   = MEM_WAIT;
        end else if (MulDivE && (MULDIV_LAT > 1)) begin
          mdStall   = 1'b1;
          mdCntNext = MDW'(MD_INIT);
          stateNext = MD_BUSY;
        end
      end
      // M only holds bubbles here, so the dmem handshake is not looked at.
      MD_BUSY: begin
        if (mdCnt != '0) begin
          mdStall   = 1'b1;
          mdCntNext = mdCnt - 1'b1;
        end else begin
          stateNext = RUN;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          stateNext = RUN;
        end else if (waitCnt == WW'(MEM_TIMEOUT)) begin
          memAbort  = 1'b1;
          stateNext = RUN;
        end else begin
          memStall    = 1'b1;
          waitCntNext = waitCnt + 1'b1;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  // Load-use only matters once the FSM lets the pipe move.
  assign lwStall = !memStall && !mdStall && (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    FlushW     = 1'b0;
    MemTimeout = 1'b0;
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;
    if (!rst) begin
      StallF     = memStall | mdStall | lwStall;
      StallD     = memStall | mdStall | lwStall;
      StallE     = memStall | mdStall;
      StallM     = memStall;
      FlushD     = PCSrcE && !StallE;
      FlushE     = (PCSrcE || lwStall) && !StallE;
      FlushM     = mdStall | memAbort;
      FlushW     = memStall;
      MemTimeout = memAbort;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                         StallCount <= '0;
    else if (StallF && ~&StallCount) StallCount <= StallCount + 1'b1;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: dut A (LAT=4, TIMEOUT=3) and dut B (LAT=1, TIMEOUT=8, 4-bit counter) share inputs.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, PCSrcE, MulDivE, MemReqM, MemReadyM;
  logic [1:0] ResultSrcE;

  logic aSF, aSD, aSE, aSM, aFD, aFE, aFM, aFW, aTO;
  logic bSF, bSD, bSE, bSM, bFD, bFE, bFM, bFW, bTO;
  logic [1:0] aFA, aFB, bFA, bFB;
  logic [31:0] aCnt;
  logic [3:0] bCnt;
  logic [8:0] ctlA, ctlB;

  int vec = 0;
  int miss = 0;

  // control vector order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,MemTimeout}
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_LW   = 9'b110001000;
  localparam logic [8:0] C_MD   = 9'b111000100;
  localparam logic [8:0] C_MEM  = 9'b111100010;
  localparam logic [8:0] C_TO   = 9'b000000101;
  localparam logic [8:0] C_BR   = 9'b000011000;
  localparam logic [8:0] C_LWBR = 9'b110011000;

  assign ctlA = {aSF, aSD, aSE, aSM, aFD, aFE, aFM, aFW, aTO};
  assign ctlB = {bSF, bSD, bSE, bSM, bFD, bFE, bFM, bFW, bTO};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_LAT(4), .MEM_TIMEOUT(3), .CNT_WIDTH(32)) dutA (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulDivE(MulDivE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .StallF(aSF), .StallD(aSD), .StallE(aSE), .StallM(aSM),
    .FlushD(aFD), .FlushE(aFE), .FlushM(aFM), .FlushW(aFW), .ForwardAE(aFA),
    .ForwardBE(aFB), .MemTimeout(aTO), .StallCount(aCnt));

  pipeline_hazard_ctrl #(.MULDIV_LAT(1), .MEM_TIMEOUT(8), .CNT_WIDTH(4)) dutB (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulDivE(MulDivE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .StallF(bSF), .StallD(bSD), .StallE(bSE), .StallM(bSM),
    .FlushD(bFD), .FlushE(bFE), .FlushM(bFM), .FlushW(bFW), .ForwardAE(bFA),
    .ForwardBE(bFB), .MemTimeout(bTO), .StallCount(bCnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MulDivE = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  initial begin
    // reset with hazard-provoking inputs: everything must stay quiet
    clearIn();
    rst = 1; MemReqM = 1; PCSrcE = 1; MulDivE = 1;
    RegWriteM = 1; RdM = 4; Rs1E = 4; ResultSrcE = 2'b01; RdE = 2; Rs1D = 2;
    #1;
    chk("rst_ctlA", 32'(ctlA), 32'(C_NONE));
    chk("rst_fwdA", 32'(aFA), 32'd0);
    step();
    chk("rst_cntA", aCnt, 32'd0);
    chk("rst_cntB", 32'(bCnt), 32'd0);
    clearIn();
    rst = 0;
    #1;
    chk("idle_ctlA", 32'(ctlA), 32'(C_NONE));

    // forwarding
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5; #1;
    chk("fwdA_M", 32'(aFA), 32'd2);
    chk("fwdB_M", 32'(aFB), 32'd2);
    RdM = 0; #1;
    chk("fwdA_W", 32'(aFA), 32'd1);
    Rs1E = 0; RdW = 0; #1;
    chk("fwdA_none", 32'(aFA), 32'd0);
    RdM = 6; RegWriteM = 0; RdW = 6; RegWriteW = 1; Rs2E = 6; #1;
    chk("fwdB_W_noM", 32'(aFB), 32'd1);
    clearIn();
    step();

    // MUL/DIV: LAT=4 -> three stall cycles, then release
    MulDivE = 1; #1;
    chk("md_c0_A", 32'(ctlA), 32'(C_MD));
    chk("md_lat1_B", 32'(ctlB), 32'(C_NONE));
    step();
    chk("md_c1_A", 32'(ctlA), 32'(C_MD));
    step();
    chk("md_c2_A", 32'(ctlA), 32'(C_MD));
    step();
    chk("md_c3_A", 32'(ctlA), 32'(C_NONE));
    step();
    MulDivE = 0; #1;
    chk("md_cntA", aCnt, 32'd3);
    chk("md_cntB", 32'(bCnt), 32'd0);

    // load-use
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; #1;
    chk("lu_A", 32'(ctlA), 32'(C_LW));
    step();
    ResultSrcE = 2'b00; RdE = 0; #1;
    chk("lu_after_A", 32'(ctlA), 32'(C_NONE));
    chk("lu_cntA", aCnt, 32'd4);
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0; #1;
    chk("lu_rd0_A", 32'(ctlA), 32'(C_NONE));
    ResultSrcE = 2'b10; RdE = 7; Rs2D = 7; #1;
    chk("lu_notload_A", 32'(ctlA), 32'(C_NONE));
    clearIn();
    step();

    // dmem timeout on A (TIMEOUT=3)
    MemReqM = 1; MemReadyM = 0; #1;
    chk("to_c0_A", 32'(ctlA), 32'(C_MEM));
    step();
    chk("to_c1_A", 32'(ctlA), 32'(C_MEM));
    step();
    chk("to_c2_A", 32'(ctlA), 32'(C_MEM));
    step();
    chk("to_c3_A", 32'(ctlA), 32'(C_TO));
    step();
    MemReqM = 0; MemReadyM = 1; #1;
    chk("to_run_A", 32'(ctlA), 32'(C_NONE));
    chk("to_relB", 32'(ctlB), 32'(C_NONE));
    step();
    MemReadyM = 0; #1;
    chk("to_cntA", aCnt, 32'd7);

    // dmem wait 5 cycles on B with a pending branch
    MemReqM = 1; PCSrcE = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("mw_c%0d_B", i), 32'(ctlB), 32'(C_MEM));
      step();
    end
    MemReadyM = 1; #1;
    chk("mw_ready_B", 32'(ctlB), 32'(C_BR));
    step();
    MemReqM = 0; MemReadyM = 0; PCSrcE = 0; #1;
    chk("mw_run_B", 32'(ctlB), 32'(C_NONE));
    chk("mw_cntA", aCnt, 32'd11);
    chk("mw_cntB", 32'(bCnt), 32'd10);

    // long wait on B: timeout after 8 stalls, counter saturates at 15
    MemReqM = 1;
    for (int i = 0; i < 8; i++) step();
    chk("sat_to_B", 32'(ctlB), 32'(C_TO));
    step();
    MemReqM = 0; MemReadyM = 1; #1;
    chk("sat_run_B", 32'(ctlB), 32'(C_NONE));
    step();
    MemReadyM = 0; #1;
    chk("sat_cntB", 32'(bCnt), 32'd15);

    // branch alone, and branch together with load-use
    PCSrcE = 1; #1;
    chk("br_A", 32'(ctlA), 32'(C_BR));
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; #1;
    chk("lwbr_A", 32'(ctlA), 32'(C_LWBR));
    clearIn();
    step();

    // reset in the middle of MD_BUSY
    MulDivE = 1;
    step();
    #1;
    chk("mdr_busy_A", 32'(ctlA), 32'(C_MD));
    rst = 1; MemReqM = 1; RegWriteW = 1; RdW = 9; Rs2E = 9; #1;
    chk("mdr_rst_ctlA", 32'(ctlA), 32'(C_NONE));
    chk("mdr_rst_fwdB", 32'(aFB), 32'd0);
    step();
    rst = 0; clearIn(); #1;
    chk("mdr_run_A", 32'(ctlA), 32'(C_NONE));
    chk("mdr_cntA", aCnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
